// File: rtl/photonic_switch_pkg.sv
// Shared constants and types for the photonic-switch controller.
package photonic_switch_pkg;
   localparam int DIV8 = 25;
   localparam int DIV1 = 8;
   localparam int CW   = 7;
   localparam int WW   = 13;
   localparam int PW   = 5;

   typedef enum logic {
      SW_RESET = 1'b0,
      SW_SET   = 1'b1
   } sw_state_t;
endpackage

// File: rtl/up_counter.sv
// Free-running up counter that wraps to zero after reaching max.
module up_counter #(
   parameter int WIDTH = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [WIDTH-1:0] max,
   output logic [WIDTH-1:0] count
);
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) count <= '0;
      else if (en) count <= (count == max) ? '0 : count + 1'b1;
   end
endmodule

// File: rtl/photonic_switch_top.sv
// Photonic-switch controller: gated frequency compare of clkA/clkB
// driving set/reset pulses into a latching optical switch.
module photonic_switch_top
   import photonic_switch_pkg::*;
(
   input  logic          clk,
   input  logic          reset,
   input  logic          en,
   input  logic          clkA,
   input  logic          clkB,
   input  logic [WW-1:0] W,
   output logic          PWMset,
   output logic          PWMreset,
   output logic          signal,
   output logic          signal_b,
   output logic [CW-1:0] cA,
   output logic [CW-1:0] cB,
   output logic [PW-1:0] c1,
   output logic [PW-1:0] c2,
   output logic          en_8MHz,
   output logic          en_1MHz,
   output logic [CW-1:0] A_val,
   output logic [CW-1:0] B_val,
   output logic          En,
   output logic          enS,
   output logic          enR
);
   localparam logic [PW-1:0] C1_MAX  = PW'(DIV8 - 1);
   localparam logic [PW-1:0] C2_MAX  = PW'(DIV1 - 1);
   localparam logic [CW-1:0] CNT_MAX = '1;

   logic [2:0]    sync_a;
   logic [2:0]    sync_b;
   logic          rise_a;
   logic          rise_b;
   logic          cap_d;
   logic [WW-1:0] t_set;
   logic [WW-1:0] t_rst;
   sw_state_t     state_q;
   sw_state_t     state_d;

   up_counter #(.WIDTH(PW)) u_c1 (
      .clk(clk), .reset(reset), .en(en), .max(C1_MAX), .count(c1)
   );

   up_counter #(.WIDTH(PW)) u_c2 (
      .clk(clk), .reset(reset), .en(en_8MHz), .max(C2_MAX), .count(c2)
   );

   assign en_8MHz = en && (c1 == C1_MAX);
   assign en_1MHz = en_8MHz && (c2 == C2_MAX);

   // bit 0/1 synchronize, bit 2 holds the previous synchronized sample
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_a <= '0;
         sync_b <= '0;
         En     <= 1'b0;
         cap_d  <= 1'b0;
      end else begin
         sync_a <= {sync_a[1:0], clkA};
         sync_b <= {sync_b[1:0], clkB};
         En     <= en;
         cap_d  <= en_1MHz;
      end
   end

   assign rise_a = sync_a[1] & ~sync_a[2];
   assign rise_b = sync_b[1] & ~sync_b[2];

   // a rise landing on the capture cycle seeds the next window
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cA    <= '0;
         A_val <= '0;
      end else if (en_1MHz) begin
         A_val <= cA;
         cA    <= CW'(rise_a & En);
      end else if (rise_a && En && cA != CNT_MAX) begin
         cA <= cA + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cB    <= '0;
         B_val <= '0;
      end else if (en_1MHz) begin
         B_val <= cB;
         cB    <= CW'(rise_b & En);
      end else if (rise_b && En && cB != CNT_MAX) begin
         cB <= cB + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= SW_RESET;
      else state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      enS     = 1'b0;
      enR     = 1'b0;
      if (cap_d) begin
         enS = (A_val > B_val) && (state_q == SW_RESET);
         enR = (B_val > A_val) && (state_q == SW_SET);
      end
      if (enS) state_d = SW_SET;
      else if (enR) state_d = SW_RESET;
   end

   // each request kills the opposite timer so the drives never overlap
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         t_set <= '0;
         t_rst <= '0;
      end else if (enS) begin
         t_set <= W;
         t_rst <= '0;
      end else if (enR) begin
         t_rst <= W;
         t_set <= '0;
      end else if (en) begin
         if (t_set != '0) t_set <= t_set - 1'b1;
         if (t_rst != '0) t_rst <= t_rst - 1'b1;
      end
   end

   assign PWMset   = (t_set != '0);
   assign PWMreset = (t_rst != '0);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         signal   <= 1'b0;
         signal_b <= 1'b0;
      end else begin
         signal   <= PWMset;
         signal_b <= PWMreset;
      end
   end
endmodule

// File: tb/tb_photonic_switch_top.sv
// Bench for photonic_switch_top: prescaler timing, window
// measurement scoreboard, pulse shaping, freeze and async reset.
`timescale 1ns/1ps
module tb_photonic_switch_top;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        en = 1'b1;
   logic        clkA = 1'b0;
   logic        clkB = 1'b0;
   logic [12:0] W = '0;
   logic        PWMset, PWMreset, signal, signal_b;
   logic [6:0]  cA, cB, A_val, B_val;
   logic [4:0]  c1, c2;
   logic        en_8MHz, en_1MHz, En, enS, enR;

   real ha = 6.25;
   real hb = 6.173;
   int  checks = 0;
   int  errors = 0;

   typedef struct {
      int a;
      int b;
      int tol;
      int req;
      int w;
   } exp_t;
   exp_t sb[$];

   photonic_switch_top dut (
      .clk(clk), .reset(reset), .en(en), .clkA(clkA), .clkB(clkB),
      .W(W), .PWMset(PWMset), .PWMreset(PWMreset), .signal(signal),
      .signal_b(signal_b), .cA(cA), .cB(cB), .c1(c1), .c2(c2),
      .en_8MHz(en_8MHz), .en_1MHz(en_1MHz), .A_val(A_val),
      .B_val(B_val), .En(En), .enS(enS), .enR(enR)
   );

   always #2.5 clk = ~clk;
   initial begin
      #0.4;
      forever #(ha) clkA = ~clkA;
   end
   initial begin
      #0.9;
      forever #(hb) clkB = ~clkB;
   end

   task automatic wait_window(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (en_1MHz) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL window_timeout: got no en_1MHz, required one within 1000 clk");
      end
   endtask

   task automatic test_reset();
      repeat (5) @(negedge clk);
      checks++;
      if ({c1, c2} !== 10'd0) begin
         errors++;
         $display("FAIL reset_prescaler: got c1=%0d c2=%0d, required 0 0", c1, c2);
      end
      checks++;
      if ({cA, cB, A_val, B_val} !== 28'd0) begin
         errors++;
         $display("FAIL reset_counts: got %0d %0d %0d %0d, required 0", cA, cB, A_val, B_val);
      end
      checks++;
      if ({PWMset, PWMreset, signal, signal_b, En, enS, enR, en_8MHz, en_1MHz} !== 9'd0) begin
         errors++;
         $display("FAIL reset_flags: got %b, required 0", {PWMset, PWMreset, signal, signal_b, En, enS, enR, en_8MHz, en_1MHz});
      end
   endtask

   task automatic test_prescaler();
      bit ok;
      int cnt;
      reset = 1'b1;
      checks++;
      if (c1 !== 5'd0) begin
         errors++;
         $display("FAIL c1_start: got %0d, required 0", c1);
      end
      for (int i = 1; i <= 50; i++) begin
         @(negedge clk);
         checks++;
         if (c1 !== 5'(i % 25) || en_8MHz !== (i % 25 == 24)) begin
            errors++;
            $display("FAIL c1_seq[%0d]: got c1=%0d tick=%b, required %0d %b", i, c1, en_8MHz, i % 25, i % 25 == 24);
         end
      end
      wait_window(ok);
      cnt = 0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         cnt++;
         if (en_1MHz) break;
      end
      checks++;
      if (cnt != 200 || c2 !== 5'd7) begin
         errors++;
         $display("FAIL window_period: got %0d clk c2=%0d, required 200 clk c2=7", cnt, c2);
      end
   endtask

   task automatic test_measure(input real na, input real nb, input int ea, input int eb, input int req, input int w);
      bit ok;
      exp_t e;
      int da, db;
      logic [3:0] want;
      wait_window(ok);
      ha = na;
      hb = nb;
      W = 13'(w);
      e = '{ea, eb, 1, req, w};
      sb.push_back(e);
      wait_window(ok);
      @(negedge clk);
      e = sb.pop_front();
      da = int'(A_val) - e.a;
      db = int'(B_val) - e.b;
      checks++;
      if (da > e.tol || da < -e.tol || db > e.tol || db < -e.tol) begin
         errors++;
         $display("FAIL measure_vals: got A=%0d B=%0d, required %0d %0d +/-%0d", A_val, B_val, e.a, e.b, e.tol);
      end
      checks++;
      if (enS !== (e.req == 1) || enR !== (e.req == 2)) begin
         errors++;
         $display("FAIL request: got enS=%b enR=%b, required req=%0d", enS, enR, e.req);
      end
      for (int k = 2; k <= e.w + 3; k++) begin
         @(negedge clk);
         if (k == 2) W = W + 13'd7;
         want[3] = (e.req == 1) && (k <= e.w + 1);
         want[2] = (e.req == 2) && (k <= e.w + 1);
         want[1] = (e.req == 1) && (k >= 3) && (k <= e.w + 2);
         want[0] = (e.req == 2) && (k >= 3) && (k <= e.w + 2);
         checks++;
         if ({PWMset, PWMreset, signal, signal_b} !== want) begin
            errors++;
            $display("FAIL pulse[%0d]: got set/rst/sig/sigb=%b, required %b", k, {PWMset, PWMreset, signal, signal_b}, want);
         end
      end
   endtask

   task automatic test_kill();
      bit ok;
      exp_t e;
      wait_window(ok);
      ha = 5.05;
      hb = 12.5;
      W = 13'd1000;
      sb.push_back('{99, 40, 1, 1, 1000});
      wait_window(ok);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (enS !== 1'b1 || int'(A_val) <= e.b) begin
         errors++;
         $display("FAIL kill_set: got enS=%b A=%0d B=%0d, required enS=1", enS, A_val, B_val);
      end
      wait_window(ok);
      ha = 12.5;
      hb = 5.05;
      W = 13'd10;
      sb.push_back('{40, 99, 1, 2, 10});
      wait_window(ok);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (enR !== 1'b1 || PWMset !== 1'b1) begin
         errors++;
         $display("FAIL kill_req: got enR=%b PWMset=%b, required 1 1", enR, PWMset);
      end
      @(negedge clk);
      checks++;
      if ({PWMset, PWMreset, signal, signal_b} !== 4'b0110) begin
         errors++;
         $display("FAIL kill_swap: got %b, required 0110", {PWMset, PWMreset, signal, signal_b});
      end
      @(negedge clk);
      checks++;
      if ({PWMset, PWMreset, signal, signal_b} !== 4'b0101) begin
         errors++;
         $display("FAIL kill_drive: got %b, required 0101", {PWMset, PWMreset, signal, signal_b});
      end
   endtask

   task automatic test_freeze();
      bit ok;
      exp_t e;
      int cnt, da, db;
      logic [23:0] snap;
      wait_window(ok);
      sb.push_back('{40, 99, 2, 0, 0});
      cnt = 0;
      snap = '0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         cnt++;
         if (cnt == 100) en = 1'b0;
         if (cnt == 102) snap = {c1, c2, cA, cB};
         if (cnt == 115) begin
            checks++;
            if ({c1, c2, cA, cB} !== snap) begin
               errors++;
               $display("FAIL freeze_hold: got %h, required %h", {c1, c2, cA, cB}, snap);
            end
            en = 1'b1;
         end
         if (en_1MHz) break;
      end
      checks++;
      if (cnt != 215) begin
         errors++;
         $display("FAIL freeze_window: got %0d clk, required 215", cnt);
      end
      @(negedge clk);
      e = sb.pop_front();
      da = int'(A_val) - e.a;
      db = int'(B_val) - e.b;
      checks++;
      if (da > e.tol || da < -e.tol || db > e.tol || db < -e.tol || enS || enR) begin
         errors++;
         $display("FAIL freeze_vals: got A=%0d B=%0d enS=%b enR=%b, required %0d %0d 0 0", A_val, B_val, enS, enR, e.a, e.b);
      end
   endtask

   task automatic test_reset_mid_pulse();
      bit ok;
      wait_window(ok);
      ha = 5.05;
      hb = 12.5;
      W = 13'd100;
      wait_window(ok);
      @(negedge clk);
      checks++;
      if (enS !== 1'b1) begin
         errors++;
         $display("FAIL mid_req: got enS=%b, required 1", enS);
      end
      repeat (10) @(negedge clk);
      checks++;
      if (PWMset !== 1'b1 || signal !== 1'b1) begin
         errors++;
         $display("FAIL mid_pulse: got PWMset=%b signal=%b, required 1 1", PWMset, signal);
      end
      #1 reset = 1'b0;
      #1;
      checks++;
      if ({PWMset, signal, A_val, cA, cB, c1, c2} !== '0) begin
         errors++;
         $display("FAIL async_reset: got set=%b sig=%b A=%0d cA=%0d cB=%0d c1=%0d c2=%0d, required 0",
                  PWMset, signal, A_val, cA, cB, c1, c2);
      end
   endtask

   initial begin
      test_reset();
      test_prescaler();
      test_measure(6.25, 6.173, 80, 81, 0, 4);
      test_measure(5.05, 12.5, 99, 40, 1, 2);
      test_measure(12.5, 5.05, 40, 99, 2, 5);
      test_measure(5.05, 12.5, 99, 40, 1, 0);
      test_measure(12.5, 5.05, 40, 99, 2, 3);
      test_kill();
      test_freeze();
      test_reset_mid_pulse();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
